opnd_skew_fifo_bank: RTL and testbench

- Per-lane operand FIFO bank between the operand SRAM read port and one edge of the PE array.
- Splits each SRAM row into NUM_LANES elements and stores each in its own lane FIFO when that lane's push bit is set.
- Pops each lane independently under the control FSM's per-lane pop bits, which produces the diagonal skew the systolic array needs.
- Two instances are used: one for opnd1 (row edge) and one for opnd2 (column edge).

---
 rtl/opnd_skew_fifo_bank_if.sv | 48 ++++
 rtl/opnd_skew_fifo_bank.sv | 133 +++++++++++++
 tb/tb_opnd_skew_fifo_bank.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/opnd_skew_fifo_bank_if.sv
// Bus between the operand-FIFO controller/SRAM side and the lane FIFO bank.
// OPND_SKEW_FIFO_LEVEL_EN adds the per-lane level and high-water-mark outputs.
interface opnd_skew_fifo_bank_if #(
    parameter int unsigned NUM_LANES  = 32,
    parameter int unsigned DATA_WIDTH = 8
`ifdef OPND_SKEW_FIFO_LEVEL_EN
    ,
    parameter int unsigned DEPTH_LOG2 = 4
`endif
);
    logic                            STALL;
    logic                            CLEAR;
    logic [NUM_LANES-1:0]            PUSHEs_in;
    logic [NUM_LANES-1:0]            POPEs_in;
    logic [NUM_LANES*DATA_WIDTH-1:0] SRAM_DATA_in;
    logic [NUM_LANES*DATA_WIDTH-1:0] DATA_out;
    logic [NUM_LANES-1:0]            VALIDs_out;
    logic [NUM_LANES-1:0]            FULLs_out;
    logic [NUM_LANES-1:0]            EMPTYs_out;
    logic                            OVERFLOW_ERR_out;
    logic                            UNDERFLOW_ERR_out;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
    logic [NUM_LANES*(DEPTH_LOG2+1)-1:0] LEVELs_out;
    logic [DEPTH_LOG2:0]                 MAX_LEVEL_out;

    modport master (
        output STALL, CLEAR, PUSHEs_in, POPEs_in, SRAM_DATA_in,
        input  DATA_out, VALIDs_out, FULLs_out, EMPTYs_out,
        input  OVERFLOW_ERR_out, UNDERFLOW_ERR_out, LEVELs_out, MAX_LEVEL_out
    );
    modport slave (
        input  STALL, CLEAR, PUSHEs_in, POPEs_in, SRAM_DATA_in,
        output DATA_out, VALIDs_out, FULLs_out, EMPTYs_out,
        output OVERFLOW_ERR_out, UNDERFLOW_ERR_out, LEVELs_out, MAX_LEVEL_out
    );
`else
    modport master (
        output STALL, CLEAR, PUSHEs_in, POPEs_in, SRAM_DATA_in,
        input  DATA_out, VALIDs_out, FULLs_out, EMPTYs_out,
        input  OVERFLOW_ERR_out, UNDERFLOW_ERR_out
    );
    modport slave (
        input  STALL, CLEAR, PUSHEs_in, POPEs_in, SRAM_DATA_in,
        output DATA_out, VALIDs_out, FULLs_out, EMPTYs_out,
        output OVERFLOW_ERR_out, UNDERFLOW_ERR_out
    );
`endif
endinterface

// File: rtl/opnd_skew_fifo_bank.sv
// Per-lane operand FIFO bank; independent per-lane pops create the systolic skew.
// Optional level/high-water-mark outputs are built when OPND_SKEW_FIFO_LEVEL_EN is defined.
module opnd_skew_fifo_bank #(
    parameter int unsigned NUM_LANES  = 32,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input logic                  CLK,
    input logic                  RSTn,
    opnd_skew_fifo_bank_if.slave bus
);
    localparam int unsigned CntW = DEPTH_LOG2 + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CntW-1:0]       cnt_t;

    logic [NUM_LANES-1:0][DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    ptr_t [NUM_LANES-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t [NUM_LANES-1:0]            count_q, count_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_LANES-1:0]            valid_q, valid_d, full_q, full_d, empty_q, empty_d;
    logic [NUM_LANES-1:0]            do_push, do_pop;
    logic                            ovf_q, ovf_d, udf_q, udf_d;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
    cnt_t                            max_level_q, max_level_d;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = valid_q;
        full_d   = full_q;
        empty_d  = empty_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        do_push  = '0;
        do_pop   = '0;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
        max_level_d = max_level_q;
`endif
        if (!bus.STALL) begin
            if (bus.CLEAR) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                data_d   = '0;
                valid_d  = '0;
                full_d   = '0;
                empty_d  = '1;
                ovf_d    = 1'b0;
                udf_d    = 1'b0;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
                max_level_d = '0;
`endif
            end else begin
                // Lanes without a pop drive zero to pad idle PEs.
                data_d  = '0;
                valid_d = '0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    do_pop[i]  = bus.POPEs_in[i] && (count_q[i] != '0);
                    // A full lane accepts a push only when a pop frees a slot the same edge.
                    do_push[i] = bus.PUSHEs_in[i] && ((count_q[i] != FullCnt) || do_pop[i]);
                    if (bus.POPEs_in[i] && !do_pop[i]) udf_d = 1'b1;
                    if (bus.PUSHEs_in[i] && !do_push[i]) ovf_d = 1'b1;
                    if (do_pop[i]) begin
                        data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rd_ptr_q[i]];
                        valid_d[i]  = 1'b1;
                        rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(1);
                    end
                    if (do_push[i]) wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(1);
                    count_d[i] = count_q[i] + cnt_t'(do_push[i]) - cnt_t'(do_pop[i]);
                    full_d[i]  = (count_d[i] == FullCnt);
                    empty_d[i] = (count_d[i] == '0);
`ifdef OPND_SKEW_FIFO_LEVEL_EN
                    if (count_d[i] > max_level_d) max_level_d = count_d[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= '0;
            full_q   <= '0;
            empty_q  <= '1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
            max_level_q <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
            max_level_q <= max_level_d;
`endif
        end
    end

    // Storage has no reset; contents are only observable through a valid pop.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (do_push[i]) mem_q[i][wr_ptr_q[i]] <= bus.SRAM_DATA_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.DATA_out          = data_q;
    assign bus.VALIDs_out        = valid_q;
    assign bus.FULLs_out         = full_q;
    assign bus.EMPTYs_out        = empty_q;
    assign bus.OVERFLOW_ERR_out  = ovf_q;
    assign bus.UNDERFLOW_ERR_out = udf_q;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
    assign bus.LEVELs_out        = count_q;
    assign bus.MAX_LEVEL_out     = max_level_q;
`endif
endmodule

// File: tb/tb_opnd_skew_fifo_bank.sv
// Scoreboard bench for opnd_skew_fifo_bank: queue-per-lane reference model, directed and random
// stimulus, and a monitor comparing every output cycle against the expected record.
module tb_opnd_skew_fifo_bank;
    localparam int NL = 32;
    localparam int DW = 8;
    localparam int DP = 16;
    localparam int CW = 5;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

`ifdef OPND_SKEW_FIFO_LEVEL_EN
    opnd_skew_fifo_bank_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .DEPTH_LOG2(4)) bus ();
`else
    opnd_skew_fifo_bank_if #(.NUM_LANES(NL), .DATA_WIDTH(DW)) bus ();
`endif

    opnd_skew_fifo_bank #(
        .NUM_LANES (NL),
        .DATA_WIDTH(DW),
        .DEPTH     (DP),
        .DEPTH_LOG2(4)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    typedef struct {
        int unsigned       cyc;
        logic [NL*DW-1:0]  data;
        logic [NL-1:0]     valid;
        logic [NL-1:0]     full;
        logic [NL-1:0]     empty;
        logic              ovf;
        logic              udf;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
        logic [NL*CW-1:0]  lvl;
        logic [CW-1:0]     maxl;
`endif
    } exp_t;

    logic [DW-1:0] mq[NL][$];
    exp_t          cur;
    exp_t          expq[$];
    int            max_lvl;
    int unsigned   cyc_cnt = 0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc_cnt, act, want);
        end
    endtask

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compares each cycle's registered outputs against the record queued for it.
    always @(negedge CLK) begin
        exp_t e;
        while (expq.size() > 0 && expq[0].cyc == cyc_cnt) begin
            e = expq.pop_front();
            chk("data", bus.DATA_out, e.data);
            chk("valid", NL*DW'(bus.VALIDs_out), NL*DW'(e.valid));
            chk("full", NL*DW'(bus.FULLs_out), NL*DW'(e.full));
            chk("empty", NL*DW'(bus.EMPTYs_out), NL*DW'(e.empty));
            chk("ovf", NL*DW'(bus.OVERFLOW_ERR_out), NL*DW'(e.ovf));
            chk("udf", NL*DW'(bus.UNDERFLOW_ERR_out), NL*DW'(e.udf));
`ifdef OPND_SKEW_FIFO_LEVEL_EN
            chk("levels", NL*DW'(bus.LEVELs_out), NL*DW'(e.lvl));
            chk("max_level", NL*DW'(bus.MAX_LEVEL_out), NL*DW'(e.maxl));
`endif
        end
    end

    task automatic step(input logic [NL-1:0] pu, input logic [NL-1:0] po,
                        input logic [NL*DW-1:0] d, input logic st, input logic cl);
        bus.PUSHEs_in    = pu;
        bus.POPEs_in     = po;
        bus.SRAM_DATA_in = d;
        bus.STALL        = st;
        bus.CLEAR        = cl;
        if (!st) begin
            if (cl) begin
                for (int i = 0; i < NL; i++) mq[i].delete();
                cur.data  = '0;
                cur.valid = '0;
                cur.ovf   = 1'b0;
                cur.udf   = 1'b0;
                max_lvl   = 0;
            end else begin
                cur.data  = '0;
                cur.valid = '0;
                for (int i = 0; i < NL; i++) begin
                    if (po[i]) begin
                        if (mq[i].size() > 0) begin
                            cur.data[i*DW +: DW] = mq[i].pop_front();
                            cur.valid[i] = 1'b1;
                        end else begin
                            cur.udf = 1'b1;
                        end
                    end
                    if (pu[i]) begin
                        if (mq[i].size() < DP) mq[i].push_back(d[i*DW +: DW]);
                        else cur.ovf = 1'b1;
                    end
                    if (mq[i].size() > max_lvl) max_lvl = mq[i].size();
                end
            end
            for (int i = 0; i < NL; i++) begin
                cur.full[i]  = (mq[i].size() == DP);
                cur.empty[i] = (mq[i].size() == 0);
`ifdef OPND_SKEW_FIFO_LEVEL_EN
                cur.lvl[i*CW +: CW] = CW'(mq[i].size());
`endif
            end
`ifdef OPND_SKEW_FIFO_LEVEL_EN
            cur.maxl = CW'(max_lvl);
`endif
        end
        cur.cyc = cyc_cnt + 1;
        expq.push_back(cur);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [NL-1:0]    m;
        logic [NL*DW-1:0] d;
        bus.PUSHEs_in = '0; bus.POPEs_in = '0; bus.SRAM_DATA_in = '0;
        bus.STALL = 1'b0; bus.CLEAR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        chk("rst_data", bus.DATA_out, '0);
        chk("rst_valid", NL*DW'(bus.VALIDs_out), '0);
        chk("rst_full", NL*DW'(bus.FULLs_out), '0);
        chk("rst_empty", NL*DW'(bus.EMPTYs_out), NL*DW'({NL{1'b1}}));
        chk("rst_errs", NL*DW'({bus.OVERFLOW_ERR_out, bus.UNDERFLOW_ERR_out}), '0);
        cur.data = '0; cur.valid = '0; cur.full = '0; cur.empty = '1;
        cur.ovf = 1'b0; cur.udf = 1'b0; max_lvl = 0;
`ifdef OPND_SKEW_FIFO_LEVEL_EN
        cur.lvl = '0; cur.maxl = '0;
`endif

        // Basic push of lanes 0..3 then pop.
        d = '0;
        for (int i = 0; i < 4; i++) d[i*DW +: DW] = 8'(8'h10 + i);
        step(32'hF, '0, d, 1'b0, 1'b0);
        step('0, 32'hF, '0, 1'b0, 1'b0);
        idle();

        // Skew: four rows into all lanes, lane i pops during cycles i..i+3.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NL; i++) d[i*DW +: DW] = 8'(k * 16 + i);
            step('1, '0, d, 1'b0, 1'b0);
        end
        for (int c = 0; c < NL + 4; c++) begin
            for (int i = 0; i < NL; i++) m[i] = (c >= i) && (c < i + 4);
            step('0, m, '0, 1'b0, 1'b0);
        end
        idle();

        // Lane 5: fill, overflow, push+pop on full, drain.
        m = '0; m[5] = 1'b1;
        for (int k = 0; k < DP + 1; k++) begin
            d = '0; d[5*DW +: DW] = 8'(8'h50 + k);
            step(m, '0, d, 1'b0, 1'b0);
        end
        d = '0; d[5*DW +: DW] = 8'hEE;
        step(m, m, d, 1'b0, 1'b0);
        for (int k = 0; k < DP; k++) step('0, m, '0, 1'b0, 1'b0);

        // Lane 7: pop on empty with simultaneous push, then pop.
        m = '0; m[7] = 1'b1;
        d = '0; d[7*DW +: DW] = 8'hAA;
        step(m, m, d, 1'b0, 1'b0);
        step('0, m, '0, 1'b0, 1'b0);

        // Lane 2: stall with pops and pushes requested, then drain.
        m = '0; m[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d = '0; d[2*DW +: DW] = 8'(8'h20 + k);
            step(m, '0, d, 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) step(m, '1, '1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step('0, m, '0, 1'b0, 1'b0);

        // Lane 3: eight entries, CLEAR with simultaneous push, then pop underflows.
        m = '0; m[3] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d = '0; d[3*DW +: DW] = 8'(8'h30 + k);
            step(m, '0, d, 1'b0, 1'b0);
        end
        step('1, '1, '1, 1'b0, 1'b1);
        step('0, m, '0, 1'b0, 1'b0);

        // Random traffic: push-biased phase then pop-biased phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 200; c++) begin
                logic [NL-1:0] pu, po;
                for (int i = 0; i < NL; i++) begin
                    pu[i] = (ph == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
                    po[i] = (ph == 0) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
                    d[i*DW +: DW] = 8'($urandom_range(255));
                end
                step(pu, po, d, $urandom_range(15) == 0, $urandom_range(63) == 0);
            end
        end
        repeat (2) idle();

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge CLK);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending want=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
